// File: rtl/fuec_12_4_pkg.sv
// Shared constants and parity function for the 12/8/4 FUEC code.
// Used by the encoder and by the optional syndrome checker.
package fuec_12_4_pkg;

  localparam int N = 12;
  localparam int K = 8;
  localparam int R = 4;

  // H columns for d7..d0, each nibble is p[3:0] contributed by that data bit
  localparam logic [K*R-1:0] H_COLS = {4'hC, 4'h6, 4'h5, 4'h7, 4'hF, 4'hB, 4'h9, 4'h3};

  function automatic logic [R-1:0] fuec_parity(input logic [K-1:0] data);
    logic [R-1:0] acc;
    acc = '0;
    for (int i = 0; i < K; i++) begin
      if (data[i]) acc = acc ^ H_COLS[i*R +: R];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fuec_syndrome_12_4.sv
// Syndrome of a 12-bit FUEC codeword {p, d}; zero for a valid codeword.
module fuec_syndrome_12_4
  import fuec_12_4_pkg::*;
(
  input  logic [N-1:0] cw,
  output logic [R-1:0] syn
);

  assign syn = fuec_parity(cw[K-1:0]) ^ cw[N-1:K];

endmodule

// File: rtl/fuec_encoder_12_4.sv
// FUEC 12/8/4 encoder: combinational parity/codeword plus a one-stage registered copy.
// Optional sticky syndrome self-check on the registered codeword: FUEC_ENC_SELFCHECK_EN.
module fuec_encoder_12_4
  import fuec_12_4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] d,
  input  logic         in_valid,
  output logic [R-1:0] p,
  output logic [N-1:0] cw,
  output logic [N-1:0] cw_q,
  output logic         out_valid,
  output logic         err_flag
);

  logic [N-1:0] cw_p1;
  logic         vld_p1;

  assign p  = fuec_parity(d);
  assign cw = {p, d};

  // ---- stage p0 -> p1: register codeword; it is reset too so cw_q starts at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) cw_p1 <= cw;
    end
  end

  assign cw_q      = cw_p1;
  assign out_valid = vld_p1;

`ifdef FUEC_ENC_SELFCHECK_EN
  logic [R-1:0] syn_p1;
  logic         err_p2;

  fuec_syndrome_12_4 u_syn (
    .cw  (cw_p1),
    .syn (syn_p1)
  );

  // ---- stage p1 -> p2: sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_p2 <= 1'b0;
    end else if (vld_p1 && (syn_p1 != '0)) begin
      err_p2 <= 1'b1;
    end
  end

  assign err_flag = err_p2;
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fuec_encoder_12_4.sv
// Scoreboard bench for fuec_encoder_12_4 with a column-sum reference model.
module tb_fuec_encoder_12_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d;
  logic        in_valid;
  logic [3:0]  p;
  logic [11:0] cw;
  logic [11:0] cw_q;
  logic        out_valid;
  logic        err_flag;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_cw;

  fuec_encoder_12_4 dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .in_valid  (in_valid),
    .p         (p),
    .cw        (cw),
    .cw_q      (cw_q),
    .out_valid (out_valid),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  // Reference: p is the GF(2) sum of the H columns of the set data bits
  function automatic logic [3:0] ref_p(input logic [7:0] x);
    logic [3:0] cols [8];
    logic [3:0] s;
    cols = '{4'h3, 4'h9, 4'hB, 4'hF, 4'h7, 4'h5, 4'h6, 4'hC};
    s = 4'h0;
    for (int i = 0; i < 8; i++) if (x[i]) s = s ^ cols[i];
    return s;
  endfunction

  function automatic logic [3:0] eq_p(input logic [7:0] x);
    logic [3:0] r;
    r[0] = x[0] ^ x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[5];
    r[1] = x[0] ^ x[2] ^ x[3] ^ x[4] ^ x[6];
    r[2] = x[3] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    r[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Drive inputs, advance one rising edge, return 1 time unit after it
  task automatic step(input logic r, input logic v, input logic [7:0] dv);
    rst = r; in_valid = v; d = dv;
    if (!r && v) exp_q.push_back({ref_p(dv), dv});
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input logic [7:0] dv, input logic [3:0] ep, input logic [11:0] ecw);
    d = dv;
    #1;
    chk("comb_p", p, ep);
    chk("comb_cw", cw, ecw);
  endtask

  // Monitor: pop one expected codeword for every presented valid output
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scb_unexpected: out_valid with empty queue, cw_q=0x%0h", cw_q);
      end else begin
        chk("scb_cw_q", cw_q, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    logic [7:0] vec_d [8];
    logic [11:0] vec_cw [8];
    vec_d  = '{8'h00, 8'h01, 8'hA7, 8'hB2, 8'hAC, 8'h3A, 8'h70, 8'hEC};
    vec_cw = '{12'h000, 12'h301, 12'h8A7, 12'h7B2, 12'hDAC, 12'h43A, 12'h470, 12'hBEC};
    rst = 1'b1; in_valid = 1'b0; d = 8'h00;

    for (int i = 0; i < 8; i++) comb(vec_d[i], vec_cw[i][11:8], vec_cw[i]);
    for (int i = 0; i < 8; i++) begin
      a = 8'h01 << i;
      comb(a, ref_p(a), {ref_p(a), a});
    end
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      comb(a, eq_p(a), {eq_p(a), a});
      chk("model_vs_eq", ref_p(a), eq_p(a));
    end
    for (int i = 0; i < 20; i++) begin
      logic [3:0] pa, pb;
      a = 8'($urandom); b = 8'($urandom);
      d = a; #1; pa = p;
      d = b; #1; pb = p;
      d = a ^ b; #1;
      chk("linearity", p, pa ^ pb);
    end

    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    chk("rst_cw_q", cw_q, 12'h000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);

    step(0, 1, 8'hA7);
    chk("pipe_cw_q", cw_q, 12'h8A7);
    chk("pipe_valid", out_valid, 1'b1);
    step(0, 0, 8'h55);
    chk("hold_cw_q", cw_q, 12'h8A7);
    chk("hold_valid", out_valid, 1'b0);

    last_cw = 12'h8A7;
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      step(0, v, a);
      if (v) last_cw = {ref_p(a), a};
      else chk("rand_hold", cw_q, last_cw);
      chk("rand_valid", out_valid, v);
    end

    step(0, 1, 8'h12);
    step(1, 1, 8'hEC);
    chk("midrst_cw_q", cw_q, 12'h000);
    chk("midrst_valid", out_valid, 1'b0);
    step(0, 0, 8'h00);

    for (int i = 0; i < 256; i++) step(0, 1, i[7:0]);
    step(0, 0, 8'h00);
    chk("err_after_all_words", err_flag, 1'b0);

`ifdef FUEC_ENC_SELFCHECK_EN
    step(0, 1, 8'hA7);
    @(negedge clk); #1;
    force dut.cw_p1 = 12'h8A6;
    step(0, 0, 8'h00);
    release dut.cw_p1;
    chk("err_set", err_flag, 1'b1);
    step(0, 0, 8'h00);
    step(0, 1, 8'h3A);
    step(0, 0, 8'h00);
    chk("err_sticky", err_flag, 1'b1);
    step(1, 0, 8'h00);
    chk("err_cleared", err_flag, 1'b0);
    step(0, 0, 8'h00);
`endif

    @(negedge clk); #1;
    chk("scb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
